osd_spi_master: RTL and testbench

On-core SPI sequencer that drives the OSD overlay's command port (SCK/SS3/DI) from core logic instead of the external IO controller. It accepts single commands through a valid/ready handshake: enable, disable, or write one 256-byte OSD line. It then serialises the command byte and payload MSB-first with a programmable bit rate. Line payload is fetched from a core-side byte source through a registered read address. It sits between core menu/status logic and the OSD block; its outputs connect directly to the OSD's SPI_SCK, SPI_SS3 and SPI_DI inputs.

---
 rtl/osd_spi_master.sv | 186 ++++++++++++++++++
 tb/tb_osd_spi_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_spi_master.sv
// SPI sequencer that drives the OSD command port (SCK/SS3/DI) from core logic.
// Sends one command byte, plus 256 fetched payload bytes for a line write, MSB first.
module osd_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_line,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_TAIL  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_EN    = 2'd1;
    localparam logic [1:0] OP_NOP   = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic [8:0] byte_q, byte_d;
    logic [7:0] sh_q, sh_d;
    logic [1:0] op_q, op_d;
    logic [7:0] addr_q, addr_d;
    logic       sck_q, sck_d;
    logic       ss3_q, ss3_d;
    logic       di_q, di_d;
    logic       rdy_q, rdy_d;
    logic       hold2_q, hold2_d;

    logic       tick;
    logic [8:0] frame_end;
    logic [7:0] cmd_byte;

    assign tick      = (div_q == 8'd0);
    assign frame_end = (op_q == OP_WRITE) ? 9'd256 : 9'd0;

    always_comb begin
        cmd_byte = 8'h40;
        if (cmd_op == OP_WRITE)   cmd_byte = 8'h20 | {5'd0, cmd_line};
        else if (cmd_op == OP_EN) cmd_byte = 8'h41;
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? div_q : div_q - 8'd1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sck_d   = sck_q;
        ss3_d   = ss3_q;
        di_d    = di_q;
        rdy_d   = rdy_q;
        hold2_d = hold2_q;
        case (state_q)
            S_IDLE: begin
                // No-op is handshaken but leaves the block idle
                if (cmd_valid && cmd_op != OP_NOP) begin
                    state_d = S_SETUP;
                    op_d    = cmd_op;
                    div_d   = DIV_LAST;
                    rdy_d   = 1'b0;
                    ss3_d   = 1'b0;
                    sck_d   = 1'b0;
                    bit_d   = 3'd0;
                    byte_d  = 9'd0;
                    sh_d    = cmd_byte;
                    di_d    = cmd_byte[7];
                    if (cmd_op == OP_WRITE) addr_d = 8'd0;
                end
            end
            S_SETUP: if (tick) begin
                state_d = S_HI;
                sck_d   = 1'b1;
                div_d   = DIV_LAST;
            end
            S_HI: if (tick) begin
                state_d = S_LO;
                sck_d   = 1'b0;
                div_d   = DIV_LAST;
                if (bit_q == 3'd7) begin
                    bit_d  = 3'd0;
                    byte_d = byte_q + 9'd1;
                    if (byte_q == frame_end) begin
                        di_d = 1'b0;
                    end else begin
                        // rd_data has settled since the previous load bumped rd_addr
                        sh_d   = rd_data;
                        di_d   = rd_data[7];
                        addr_d = addr_q + 8'd1;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = {sh_q[6:0], 1'b0};
                    di_d  = sh_q[6];
                end
            end
            S_LO: if (tick) begin
                div_d = DIV_LAST;
                if (byte_q > frame_end) begin
                    state_d = S_TAIL;
                end else begin
                    state_d = S_HI;
                    sck_d   = 1'b1;
                end
            end
            S_TAIL: if (tick) begin
                state_d = S_HOLD;
                ss3_d   = 1'b1;
                di_d    = 1'b0;
                hold2_d = 1'b0;
                div_d   = DIV_LAST;
            end
            S_HOLD: if (tick) begin
                // Two divider periods with SS3 high so the OSD resets its counters
                if (!hold2_q) begin
                    hold2_d = 1'b1;
                    div_d   = DIV_LAST;
                end else begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
                ss3_d   = 1'b1;
                sck_d   = 1'b0;
                di_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            byte_q  <= 9'd0;
            sh_q    <= 8'd0;
            op_q    <= 2'd0;
            addr_q  <= 8'd0;
            sck_q   <= 1'b0;
            ss3_q   <= 1'b1;
            di_q    <= 1'b0;
            rdy_q   <= 1'b1;
            hold2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sck_q   <= sck_d;
            ss3_q   <= ss3_d;
            di_q    <= di_d;
            rdy_q   <= rdy_d;
            hold2_q <= hold2_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign busy      = !rdy_q;
    assign rd_addr   = addr_q;
    assign SPI_SCK   = sck_q;
    assign SPI_SS3   = ss3_q;
    assign SPI_DI    = di_q;
endmodule

// File: tb/tb_osd_spi_master.sv
// Scoreboard bench: stimulus queues expected frames/busy times, monitors decode SPI and compare.
module tb_osd_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       v1 = 1'b0, v2 = 1'b0;
    logic [1:0] op1 = 2'd3, op2 = 2'd3;
    logic [2:0] ln1 = 3'd0, ln2 = 3'd0;
    logic       rdy1, busy1, sck1, ss31, di1;
    logic       rdy2, busy2, sck2, ss32, di2;
    logic [7:0] addr1, addr2, rdd1;
    logic [7:0] rdd2 = 8'h00;

    osd_spi_master #(.CLK_DIV(2)) dut1 (
        .clk_sys(clk), .reset(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
        .cmd_line(ln1), .rd_addr(addr1), .rd_data(rdd1), .busy(busy1),
        .SPI_SCK(sck1), .SPI_SS3(ss31), .SPI_DI(di1));

    osd_spi_master #(.CLK_DIV(255)) dut2 (
        .clk_sys(clk), .reset(rst), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_op(op2),
        .cmd_line(ln2), .rd_addr(addr2), .rd_data(rdd2), .busy(busy2),
        .SPI_SCK(sck2), .SPI_SS3(ss32), .SPI_DI(di2));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Core-side byte source: registered read, one cycle latency
    int pattern = 0;
    function automatic logic [7:0] pay(input int pat, input logic [7:0] a);
        return (pat == 0) ? ~a : 8'(a * 7 + 3);
    endfunction
    always @(posedge clk) rdd1 <= pay(pattern, addr1);

    typedef struct {
        int nbits;
        int ss3_low;
    } frame_t;
    frame_t     exp_fr[$];
    logic [7:0] exp_by[$];
    int         exp_busy[$];
    bit         skip_frame = 0, skip_busy = 0;

    // OSD model
    logic [7:0] osd_buf [0:2047];
    logic       osd_en  = 1'b0;
    logic [7:0] osd_cmd = 8'h00;
    function void osd_write(input int idx, input logic [7:0] b);
        if (idx == 0) begin
            osd_cmd = b;
            if (b == 8'h41) osd_en = 1'b1;
            else if (b == 8'h40) osd_en = 1'b0;
        end else if (osd_cmd[7:3] == 5'b00100 && idx <= 256) begin
            osd_buf[{osd_cmd[2:0], 8'(idx - 1)}] = b;
        end
    endfunction

    // Monitor for the CLK_DIV=2 instance
    logic       p_sck = 1'b0, p_ss3 = 1'b1, p_rdy = 1'b1;
    logic [7:0] cur = 8'h00;
    logic [7:0] got[$];
    int         m_bits = 0, ss3_cnt = 0, busy_cnt = 0;
    always @(negedge clk) begin : mon1
        frame_t f;
        int bad;
        if (ss31 === 1'b0) ss3_cnt++;
        if (rdy1 === 1'b0) busy_cnt++;
        if (sck1 === 1'b1 && !p_sck) begin
            if (ss31) chk("sck_pulse_while_ss3_high", 1, 0);
            else begin
                cur = {cur[6:0], di1};
                m_bits++;
                if (m_bits % 8 == 0) begin
                    got.push_back(cur);
                    osd_write(m_bits / 8 - 1, cur);
                end
            end
        end
        if (ss31 === 1'b1 && !p_ss3) begin
            if (skip_frame) skip_frame = 0;
            else if (exp_fr.size() == 0) chk("unexpected_frame_bits", m_bits, 0);
            else begin
                f = exp_fr.pop_front();
                chk("frame_bits", m_bits, f.nbits);
                chk("ss3_low_cycles", ss3_cnt, f.ss3_low);
                bad = 0;
                for (int i = 0; i < f.nbits / 8; i++) begin
                    if (i >= got.size() || got[i] !== exp_by[0]) bad++;
                    void'(exp_by.pop_front());
                end
                chk("frame_byte_errors", bad, 0);
            end
            m_bits = 0; ss3_cnt = 0; got.delete();
        end
        if (rdy1 === 1'b1 && !p_rdy) begin
            if (skip_busy) skip_busy = 0;
            else if (exp_busy.size() == 0) chk("unexpected_busy_cycles", busy_cnt, 0);
            else chk("busy_cycles", busy_cnt, exp_busy.pop_front());
            busy_cnt = 0;
        end
        p_sck = (sck1 === 1'b1); p_ss3 = (ss31 !== 1'b0); p_rdy = (rdy1 !== 1'b0);
    end

    // Monitor for the CLK_DIV=255 instance
    logic [7:0] exp2_by[$];
    int         exp2_busy[$];
    logic       q_sck = 1'b0, q_ss3 = 1'b1, q_rdy = 1'b1, q_di = 1'b0;
    logic [7:0] cur2 = 8'h00;
    int         hi_run = 0, lo_run = 0, per_err = 0, di_err = 0, b2cnt = 0, bz2 = 0;
    always @(negedge clk) begin : mon2
        if (rdy2 === 1'b0) bz2++;
        if (ss32 === 1'b0) begin
            if (sck2 && !q_sck) begin
                if (lo_run != 255) per_err++;
                lo_run = 0;
                cur2 = {cur2[6:0], di2};
                b2cnt++;
            end
            if (!sck2 && q_sck) begin
                if (hi_run != 255) per_err++;
                hi_run = 0;
            end
            if (sck2) hi_run++; else lo_run++;
            if (di2 !== q_di && sck2) di_err++;
        end
        if (ss32 === 1'b1 && !q_ss3) begin
            if (exp2_by.size() == 0) chk("d255_unexpected_frame", b2cnt, 0);
            else begin
                chk("d255_byte", int'(cur2), int'(exp2_by.pop_front()));
                chk("d255_bits", b2cnt, 8);
                chk("d255_half_period_errors", per_err, 0);
                chk("d255_di_change_while_sck_high", di_err, 0);
            end
            hi_run = 0; lo_run = 0; per_err = 0; di_err = 0; b2cnt = 0;
        end
        if (rdy2 === 1'b1 && !q_rdy) begin
            if (exp2_busy.size() == 0) chk("d255_unexpected_busy", bz2, 0);
            else chk("d255_busy_cycles", bz2, exp2_busy.pop_front());
            bz2 = 0;
        end
        q_sck = (sck2 === 1'b1); q_ss3 = (ss32 !== 1'b0);
        q_rdy = (rdy2 !== 1'b0); q_di = (di2 === 1'b1);
    end

    task automatic expect_frame(input logic [7:0] cmd, input int npay, input int pat,
                                input int ss3_low, input int bz);
        exp_fr.push_back('{8 * (1 + npay), ss3_low});
        exp_by.push_back(cmd);
        for (int i = 0; i < npay; i++) exp_by.push_back(pay(pat, 8'(i)));
        exp_busy.push_back(bz);
    endtask

    task automatic send1(input logic [1:0] op, input logic [2:0] ln);
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy1 && t < 20000) begin @(negedge clk); t++; end
        if (!rdy1) chk("ready_wait_timeout", 0, 1);
        op1 = op; ln1 = ln; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; op1 = 2'd3;
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while ((exp_fr.size() != 0 || exp_busy.size() != 0 || skip_frame || skip_busy)
               && t < 20000) begin
            @(negedge clk); t++;
        end
        if (t >= 20000) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        int bad, t, act;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", rdy1, 1);
        chk("reset_busy", busy1, 0);
        chk("reset_sck", sck1, 0);
        chk("reset_ss3", ss31, 1);
        chk("reset_di", di1, 0);
        chk("reset_rd_addr", addr1, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Enable: 0x41, SS3 low 36, busy 40
        expect_frame(8'h41, 0, 0, 36, 40);
        send1(2'd1, 3'd0);
        wait_done("enable");
        chk("osd_enable_bit", osd_en, 1);

        // Write line 5 with ~addr, plus an ignored command mid-frame
        pattern = 0;
        expect_frame(8'h25, 256, 0, 8228, 8232);
        send1(2'd0, 3'd5);
        repeat (300) @(negedge clk);
        chk("busy_during_write", busy1, 1);
        op1 = 2'd1; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; op1 = 2'd3;
        wait_done("write5");

        // No-op while idle: no SS3 activity, ready stays high
        op1 = 2'd3; v1 = 1'b1;
        @(negedge clk);
        chk("nop_ready", rdy1, 1);
        v1 = 1'b0;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ss31 || !rdy1) act++;
        end
        chk("nop_activity_cycles", act, 0);

        // Write line 3 and check the OSD buffer contents
        pattern = 1;
        expect_frame(8'h23, 256, 1, 8228, 8232);
        send1(2'd0, 3'd3);
        wait_done("write3");
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (osd_buf[11'h300 + 11'(i)] !== pay(1, 8'(i))) bad++;
        chk("osd_line3_errors", bad, 0);

        expect_frame(8'h40, 0, 0, 36, 40);
        send1(2'd2, 3'd0);
        wait_done("disable");
        chk("osd_disable_bit", osd_en, 0);

        // Abort a write at bit 1000 with reset
        pattern = 0;
        skip_frame = 1; skip_busy = 1;
        send1(2'd0, 3'd1);
        t = 0;
        while (m_bits < 1000 && t < 10000) begin @(negedge clk); t++; end
        chk("abort_reached_bit1000", (m_bits >= 1000) ? 1 : 0, 1);
        chk("abort_midframe_ss3", ss31, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ss3", ss31, 1);
        chk("abort_sck", sck1, 0);
        chk("abort_di", di1, 0);
        chk("abort_ready", rdy1, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done("abort");

        expect_frame(8'h41, 0, 0, 36, 40);
        send1(2'd1, 3'd0);
        wait_done("enable_after_abort");
        chk("osd_enable_after_abort", osd_en, 1);

        // CLK_DIV=255 disable frame
        exp2_by.push_back(8'h40);
        exp2_busy.push_back(5100);
        @(negedge clk);
        op2 = 2'd2; v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0; op2 = 2'd3;
        t = 0;
        while ((exp2_by.size() != 0 || exp2_busy.size() != 0) && t < 8000) begin
            @(negedge clk); t++;
        end
        if (t >= 8000) chk("d255_timeout", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
